// File: rtl/plic_arbiter.sv
// Platform interrupt arbiter: per-source gateways (sync, edge detect, pending),
// priority/threshold arbitration and a committed offer/claim/complete handshake.
module plic_arbiter #(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic               ex_trap_valid_o,
  output logic [4:0]         ex_trap_id_o,
  input  logic               ex_trap_ready_i,
  input  logic               ex_trap_cplet_i,
  input  logic               cfg_we_i,
  input  logic [7:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_BUSY} state_t;

  localparam logic [7:0] ADDR_ENABLE    = 8'h00;
  localparam logic [7:0] ADDR_THRESHOLD = 8'h04;
  localparam logic [7:0] ADDR_PENDING   = 8'h08;
  localparam logic [7:0] ADDR_INSERVICE = 8'h0C;

  state_t              r_state, w_state_nxt;
  logic                r_valid, w_valid_nxt;
  logic [4:0]          r_id, w_id_nxt;
  logic [NUM_SRC-1:0]  r_sync1, r_sync2, r_irq_prev;
  logic [NUM_SRC-1:0]  r_pending, r_enable;
  logic [PRIO_W-1:0]   r_threshold;
  logic [PRIO_W-1:0]   r_prio [NUM_SRC];

  logic [NUM_SRC-1:0]  w_edge, w_claim_mask, w_clear_mask;
  logic                w_any;
  logic [4:0]          w_win_id;
  logic [PRIO_W-1:0]   w_win_prio;
  logic                w_prio_sel;
  logic [3:0]          w_prio_idx;
  logic                w_unused;

  assign w_unused = ^{cfg_wdata_i, cfg_addr_i};

  // The source named by r_id is claimed in OFFER and BUSY; its edges are dropped.
  assign w_edge       = r_sync2 & ~r_irq_prev;
  assign w_claim_mask = (r_state != ST_IDLE) ? (NUM_SRC'(1) << r_id) : '0;
  assign w_clear_mask = (r_state == ST_OFFER && ex_trap_ready_i) ? w_claim_mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_irq_prev <= '0;
      r_pending  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_sync1    <= irq_i;
      r_sync2    <= r_sync1;
      r_irq_prev <= r_sync2;
      r_pending  <= (r_pending | (w_edge & ~w_claim_mask)) & ~w_clear_mask;
    end
  end

  // Ascending scan with strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    w_any      = 1'b0;
    w_win_id   = '0;
    w_win_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_pending[i] && r_enable[i] && (r_prio[i] > r_threshold) &&
          (!w_any || (r_prio[i] > w_win_prio))) begin
        w_any      = 1'b1;
        w_win_id   = 5'(i);
        w_win_prio = r_prio[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_id    <= w_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_OFFER;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_win_id;
        end
      end
      ST_OFFER: begin
        if (ex_trap_ready_i) begin
          w_state_nxt = ST_BUSY;
          w_valid_nxt = 1'b0;
        end
      end
      ST_BUSY: begin
        if (ex_trap_cplet_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign ex_trap_valid_o = r_valid;
  assign ex_trap_id_o    = r_id;

  assign w_prio_idx = cfg_addr_i[5:2];
  assign w_prio_sel = (cfg_addr_i[7:6] == 2'b01) && (cfg_addr_i[1:0] == 2'b00) &&
                      ({28'd0, w_prio_idx} < 32'(NUM_SRC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= '0;
      r_threshold <= '0;
      // NOTE: the priority array is a small register file that must read 0
      // after reset, so every entry is reset explicitly rather than left as RAM.
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
    end else if (cfg_we_i) begin
      if (cfg_addr_i == ADDR_ENABLE)    r_enable    <= cfg_wdata_i[NUM_SRC-1:0];
      if (cfg_addr_i == ADDR_THRESHOLD) r_threshold <= cfg_wdata_i[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_prio_sel && (w_prio_idx == 4'(i))) r_prio[i] <= cfg_wdata_i[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      ADDR_ENABLE:    cfg_rdata_o[NUM_SRC-1:0] = r_enable;
      ADDR_THRESHOLD: cfg_rdata_o[PRIO_W-1:0]  = r_threshold;
      ADDR_PENDING:   cfg_rdata_o[NUM_SRC-1:0] = r_pending;
      ADDR_INSERVICE: begin
        cfg_rdata_o[0]   = (r_state == ST_BUSY);
        cfg_rdata_o[8:4] = (r_state == ST_BUSY) ? r_id : 5'd0;
      end
      default: begin
        if (w_prio_sel) cfg_rdata_o[PRIO_W-1:0] = r_prio[w_prio_idx];
      end
    endcase
  end

endmodule

// File: tb/tb_plic_arbiter.sv
// Bench for plic_arbiter: register vector table plus scoreboarded offer sequences
// covering priority, masking, committed offers, gateway blocking and reset.
module tb_plic_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] irq;
  logic        valid;
  logic [4:0]  id;
  logic        ready, cplet, we;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t zero_vecs[$];
  vec_t rw_vecs[$];

  plic_arbiter #(.NUM_SRC(16), .PRIO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq),
    .ex_trap_valid_o(valid), .ex_trap_id_o(id),
    .ex_trap_ready_i(ready), .ex_trap_cplet_i(cplet),
    .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata), .cfg_rdata_o(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] e);
    addr = a;
    #1;
    check(name, rdata, e);
  endtask

  task automatic do_reset();
    irq = '0; ready = 1'b0; cplet = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_irq(input logic [15:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic wait_offer(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin got = 1'b1; break; end
      tick();
    end
    if (!got) check({name, " offer timeout"}, 32'(got), 32'd1);
    else if (exp_q.size() == 0) check({name, " unexpected offer"}, 32'(exp_q.size()), 32'd1);
    else check({name, " offer id"}, 32'(id), 32'(exp_q.pop_front()));
  endtask

  task automatic ready_pulse();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("valid drops on claim", 32'(valid), 32'd0);
  endtask

  task automatic cplet_pulse();
    cplet = 1'b1;
    tick();
    cplet = 1'b0;
  endtask

  task automatic handshake();
    ready_pulse();
    tick();
    cplet_pulse();
    check("idle right after cplet", 32'(valid), 32'd0);
  endtask

  task automatic run_zero_table(input string name);
    foreach (zero_vecs[i]) rd_check($sformatf("%s addr 0x%0h", name, zero_vecs[i].addr),
                                    zero_vecs[i].addr, zero_vecs[i].exp);
  endtask

  initial begin
    logic seen;

    zero_vecs.push_back('{1'b0, 8'h00, 32'h0, 32'h0});
    zero_vecs.push_back('{1'b0, 8'h04, 32'h0, 32'h0});
    zero_vecs.push_back('{1'b0, 8'h08, 32'h0, 32'h0});
    zero_vecs.push_back('{1'b0, 8'h0C, 32'h0, 32'h0});
    zero_vecs.push_back('{1'b0, 8'h40, 32'h0, 32'h0});
    zero_vecs.push_back('{1'b0, 8'h48, 32'h0, 32'h0});
    zero_vecs.push_back('{1'b0, 8'h7C, 32'h0, 32'h0});

    rw_vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0000_FFFF});
    rw_vecs.push_back('{1'b1, 8'h04, 32'hFFFF_FFFE, 32'h0000_0006});
    rw_vecs.push_back('{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0000_0000});
    rw_vecs.push_back('{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0000_0000});
    rw_vecs.push_back('{1'b1, 8'h40, 32'h0000_0012, 32'h0000_0002});
    rw_vecs.push_back('{1'b1, 8'h7C, 32'h0000_0005, 32'h0000_0005});
    rw_vecs.push_back('{1'b1, 8'h80, 32'hFFFF_FFFF, 32'h0000_0000});
    rw_vecs.push_back('{1'b1, 8'hFC, 32'h0000_0007, 32'h0000_0000});
    rw_vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_FFFF});
    rw_vecs.push_back('{1'b0, 8'h40, 32'h0,         32'h0000_0002});

    // Reset state and register map
    do_reset();
    check("reset valid", 32'(valid), 32'd0);
    check("reset id", 32'(id), 32'd0);
    run_zero_table("reset reg");
    foreach (rw_vecs[i]) begin
      if (rw_vecs[i].we) cfg_write(rw_vecs[i].addr, rw_vecs[i].wdata);
      rd_check($sformatf("regmap addr 0x%0h", rw_vecs[i].addr), rw_vecs[i].addr, rw_vecs[i].exp);
    end

    // Basic claim/complete with exact latency
    do_reset();
    cfg_write(8'h00, 32'h0004);
    cfg_write(8'h48, 32'd3);
    cfg_write(8'h04, 32'd1);
    pulse_irq(16'h0004);
    exp_q.push_back(5'd2);
    tick();
    tick();
    rd_check("basic pending at E+2", 8'h08, 32'h4);
    check("basic valid low at E+2", 32'(valid), 32'd0);
    tick();
    check("basic valid at E+3", 32'(valid), 32'd1);
    wait_offer("basic");
    ready_pulse();
    rd_check("basic pending after claim", 8'h08, 32'h0);
    rd_check("basic inservice busy", 8'h0C, 32'h21);
    cplet_pulse();
    rd_check("basic inservice after cplet", 8'h0C, 32'h0);

    // Priority order and tie-break: 5, 9, 1
    do_reset();
    cfg_write(8'h00, 32'h0222);
    cfg_write(8'h44, 32'd2);
    cfg_write(8'h54, 32'd6);
    cfg_write(8'h64, 32'd6);
    pulse_irq(16'h0222);
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd9);
    exp_q.push_back(5'd1);
    wait_offer("prio first");
    handshake();
    tick();
    check("prio reoffer at C+1", 32'(valid), 32'd1);
    wait_offer("prio second");
    handshake();
    tick();
    check("prio third at C+1", 32'(valid), 32'd1);
    wait_offer("prio third");
    handshake();

    // Threshold and enable masking
    do_reset();
    cfg_write(8'h4C, 32'd2);
    cfg_write(8'h50, 32'd5);
    cfg_write(8'h04, 32'd2);
    cfg_write(8'h00, 32'h0008);
    pulse_irq(16'h0018);
    seen = 1'b0;
    repeat (6) begin tick(); seen |= valid; end
    check("masked no offer", 32'(seen), 32'd0);
    rd_check("masked pending", 8'h08, 32'h18);
    cfg_write(8'h04, 32'd1);
    check("threshold write edge no valid", 32'(valid), 32'd0);
    tick();
    check("threshold offer one cycle after write", 32'(valid), 32'd1);
    exp_q.push_back(5'd3);
    wait_offer("threshold");
    handshake();
    tick();
    check("disabled source stays idle", 32'(valid), 32'd0);
    cfg_write(8'h00, 32'h0018);
    check("enable write edge no valid", 32'(valid), 32'd0);
    tick();
    check("enable offer one cycle after write", 32'(valid), 32'd1);
    exp_q.push_back(5'd4);
    wait_offer("enable");
    handshake();

    // Committed offer
    do_reset();
    cfg_write(8'h00, 32'h0081);
    cfg_write(8'h5C, 32'd4);
    cfg_write(8'h40, 32'd7);
    pulse_irq(16'h0080);
    exp_q.push_back(5'd7);
    wait_offer("commit");
    cfg_write(8'h00, 32'h0001);
    pulse_irq(16'h0001);
    exp_q.push_back(5'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("commit hold cycle %0d", i), {26'd0, valid, id}, {26'd0, 1'b1, 5'd7});
    end
    handshake();
    wait_offer("commit after cplet");
    handshake();

    // Gateway blocking while claimed
    do_reset();
    cfg_write(8'h00, 32'h0004);
    cfg_write(8'h48, 32'd3);
    pulse_irq(16'h0004);
    exp_q.push_back(5'd2);
    wait_offer("gateway");
    ready_pulse();
    pulse_irq(16'h0004);
    repeat (3) tick();
    rd_check("gateway pending blocked", 8'h08, 32'h0);
    cplet_pulse();
    seen = 1'b0;
    repeat (5) begin tick(); seen |= valid; end
    check("gateway no reoffer", 32'(seen), 32'd0);
    pulse_irq(16'h0004);
    exp_q.push_back(5'd2);
    wait_offer("gateway after cplet");
    handshake();

    // Spurious handshakes and reset mid-offer
    do_reset();
    cplet_pulse();
    check("spurious cplet valid", 32'(valid), 32'd0);
    rd_check("spurious cplet inservice", 8'h0C, 32'h0);
    cfg_write(8'h00, 32'h0004);
    cfg_write(8'h48, 32'd3);
    pulse_irq(16'h0004);
    exp_q.push_back(5'd2);
    wait_offer("spurious");
    ready_pulse();
    rd_check("spurious busy inservice", 8'h0C, 32'h21);
    ready_pulse();
    rd_check("spurious ready inservice", 8'h0C, 32'h21);
    cplet_pulse();
    rd_check("spurious after cplet", 8'h0C, 32'h0);
    pulse_irq(16'h0004);
    exp_q.push_back(5'd2);
    wait_offer("reset offer");
    #2 rst_n = 1'b0;
    #1;
    check("mid-offer reset valid", 32'(valid), 32'd0);
    check("mid-offer reset id", 32'(id), 32'd0);
    run_zero_table("mid-offer reset reg");
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= valid; end
    check("no offer after reset", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
